// File: rtl/segment_translate_unit_pkg.sv
// Shared definitions for the segment translation unit.
//   - fault codes reported on rsp_fault
//   - reset-time descriptor permissions (code segment read-only,
//     every other segment writable); base resets to 0 and limit to all-ones
package segment_translate_unit_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE   = 2'd0,
    FAULT_LIMIT  = 2'd1,
    FAULT_WPROT  = 2'd2,
    FAULT_BADIDX = 2'd3
  } fault_e;

  localparam logic RST_WRITABLE_CODE = 1'b0;
  localparam logic RST_WRITABLE_DATA = 1'b1;

  // Segment 0 holds code and comes out of reset write-protected.
  function automatic logic rst_writable(input int idx);
    return (idx == 0) ? RST_WRITABLE_CODE : RST_WRITABLE_DATA;
  endfunction

endpackage

// File: rtl/segment_translate_unit_if.sv
// Request/response bus of the segment translation unit.
//   master: issues req_* (valid/ready), consumes rsp_* (valid/ready)
//   slave : the translation unit
interface segment_translate_unit_if #(
  parameter int ADDR_W = 20,
  parameter int OFF_W  = 16,
  parameter int SEG_IW = 2
);

  logic              req_valid;
  logic              req_ready;
  logic [SEG_IW-1:0] req_seg;
  logic [OFF_W-1:0]  req_offset;
  logic              req_write;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_seg, req_offset, req_write, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_seg, req_offset, req_write, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_fault
  );

endinterface

// File: rtl/segment_translate_unit_addr_calc.sv
// Combinational segment address calculation.
//   base       : segment base (shifted left by SEG_SHIFT before the add)
//   limit      : inclusive maximum offset
//   offset     : offset within the segment
//   addr       : physical address, wraps silently modulo 2^ADDR_W
//   over_limit : offset exceeds limit
module segment_translate_unit_addr_calc #(
  parameter int ADDR_W    = 20,
  parameter int OFF_W     = 16,
  parameter int SEG_SHIFT = 4
) (
  input  logic [ADDR_W-SEG_SHIFT-1:0] base,
  input  logic [OFF_W-1:0]            limit,
  input  logic [OFF_W-1:0]            offset,
  output logic [ADDR_W-1:0]           addr,
  output logic                        over_limit
);

  localparam int SUM_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

  logic [ADDR_W-1:0] base_sh;
  logic [SUM_W-1:0]  sum;

  assign base_sh    = {base, {SEG_SHIFT{1'b0}}};
  assign sum        = SUM_W'(base_sh) + SUM_W'(offset);
  assign addr       = sum[ADDR_W-1:0];
  assign over_limit = (offset > limit);

endmodule

// File: rtl/segment_translate_unit.sv
// Segment translation unit: NUM_SEGS segment descriptors, an instruction
// pointer, and a one-stage valid/ready pipeline turning (segment, offset)
// requests into physical addresses with fault flags.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_*             : descriptor write port (applied at the edge)
//   bus (slave)       : req_* request handshake, rsp_* response handshake
//   ip_load/ip_inc    : instruction pointer load (wins) / advance by IP_STEP
//   ip, fetch_addr    : current pointer and its address in segment 0
//   ip_fault          : ip beyond the limit of segment 0
module segment_translate_unit
  import segment_translate_unit_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int OFF_W     = 16,
  parameter int SEG_SHIFT = 4,
  parameter int NUM_SEGS  = 4,
  parameter int IP_STEP   = 2,
  localparam int SEG_IW   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
  localparam int BASE_W   = ADDR_W - SEG_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [SEG_IW-1:0]     cfg_seg,
  input  logic [BASE_W-1:0]     cfg_base,
  input  logic [OFF_W-1:0]      cfg_limit,
  input  logic                  cfg_writable,
  segment_translate_unit_if.slave bus,
  input  logic                  ip_load,
  input  logic [OFF_W-1:0]      ip_load_val,
  input  logic                  ip_inc,
  output logic [OFF_W-1:0]      ip,
  output logic [ADDR_W-1:0]     fetch_addr,
  output logic                  ip_fault
);

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [OFF_W-1:0]  limit;
    logic              writable;
  } desc_t;

  desc_t             desc_q [NUM_SEGS];

  logic              req_bad;
  logic [SEG_IW-1:0] req_sel;
  desc_t             req_desc;
  logic [ADDR_W-1:0] req_addr;
  logic              req_over;
  logic [ADDR_W-1:0] req_addr_chk;
  fault_e            req_fault;
  logic              accept;
  logic              cfg_hit;

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  fault_e            fault_p0;
  logic [OFF_W-1:0]  ip_q;

  // An out-of-range index is steered to segment 0 so the lookup stays in
  // bounds; its result is discarded by the bad-index fault below.
  assign req_bad  = (32'(bus.req_seg) >= NUM_SEGS);
  assign req_sel  = req_bad ? '0 : bus.req_seg;
  assign req_desc = desc_q[req_sel];

  segment_translate_unit_addr_calc #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .SEG_SHIFT (SEG_SHIFT)
  ) u_req_calc (
    .base       (req_desc.base),
    .limit      (req_desc.limit),
    .offset     (bus.req_offset),
    .addr       (req_addr),
    .over_limit (req_over)
  );

  always_comb begin
    req_fault    = FAULT_NONE;
    req_addr_chk = req_addr;
    if (req_bad) begin
      req_fault    = FAULT_BADIDX;
      req_addr_chk = '0;
    end else if (req_over) begin
      req_fault = FAULT_LIMIT;
    end else if (bus.req_write && !req_desc.writable) begin
      req_fault = FAULT_WPROT;
    end
  end

  assign bus.req_ready = !vld_p0 || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // ---- stage p0: registered response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      fault_p0 <= FAULT_NONE;
    end else if (accept) begin
      vld_p0   <= 1'b1;
      addr_p0  <= req_addr_chk;
      fault_p0 <= req_fault;
    end else if (bus.rsp_ready) begin
      vld_p0   <= 1'b0;
    end
  end

  assign bus.rsp_valid = vld_p0;
  assign bus.rsp_addr  = addr_p0;
  assign bus.rsp_fault = fault_p0;

  // Descriptor writes land at the edge, so a same-cycle request to the same
  // segment has already sampled the old values.
  assign cfg_hit = cfg_we && (32'(cfg_seg) < NUM_SEGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        desc_q[i].base     <= '0;
        desc_q[i].limit    <= '1;
        desc_q[i].writable <= rst_writable(i);
      end
    end else if (cfg_hit) begin
      desc_q[cfg_seg] <= '{base: cfg_base, limit: cfg_limit, writable: cfg_writable};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ip_q <= '0;
    end else if (ip_load) begin
      ip_q <= ip_load_val;
    end else if (ip_inc) begin
      ip_q <= ip_q + OFF_W'(IP_STEP);
    end
  end

  assign ip = ip_q;

  segment_translate_unit_addr_calc #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .SEG_SHIFT (SEG_SHIFT)
  ) u_fetch_calc (
    .base       (desc_q[0].base),
    .limit      (desc_q[0].limit),
    .offset     (ip_q),
    .addr       (fetch_addr),
    .over_limit (ip_fault)
  );

endmodule
